// File: rtl/axi_lite_write_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_write_slave_if
//  Description : AXI4-Lite write-path bundle (AW, W and B channels).
//                The master modport drives AWVALID/AWADDR, WVALID/WDATA/WSTRB
//                and BREADY. The slave modport drives AWREADY, WREADY, BVALID
//                and BRESP.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_lite_write_slave_if;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] AWADDR;
   logic        WVALID;
   logic        WREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        BVALID;
   logic        BREADY;
   logic [1:0]  BRESP;

   modport master (
      output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
      input  AWREADY, WREADY, BVALID, BRESP
   );

   modport slave (
      input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY,
      output AWREADY, WREADY, BVALID, BRESP
   );
endinterface
`default_nettype wire

// File: rtl/axi_lite_write_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi_lite_write_slave
//  Description : AXI4-Lite write responder with a register file.
//                The AW and W beats are collected independently and in either
//                order. Once both are held, a byte-strobed write is performed
//                and B is returned. The registers are exported flat on
//                reg_out.
//  Ports       : ACLK     - clock, rising edge
//                ARESET   - asynchronous, active-low reset
//                s_axi    - AW/W/B channels (slave modport)
//                reg_out  - register k at [32k+31:32k]
//                wr_pulse - one-cycle strobe after an OKAY write
//                wr_index - register index written, valid with wr_pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_write_slave #(
   parameter int NUM_REGS = 4,
   parameter int ADDR_LSB = 2
) (
   input  wire logic                        ACLK,
   input  wire logic                        ARESET,
   axi_lite_write_slave_if.slave            s_axi,
   output logic [NUM_REGS*32-1:0]           reg_out,
   output logic                             wr_pulse,
   output logic [$clog2(NUM_REGS)-1:0]      wr_index
);

   localparam int         c_IDX_W  = $clog2(NUM_REGS);
   localparam logic [1:0] c_OKAY   = 2'b00;
   localparam logic [1:0] c_SLVERR = 2'b10;

   typedef enum logic [0:0] {
      S_COLLECT = 1'b0,
      S_RESP    = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_next;

   logic                 r_aw_held;
   logic                 r_w_held;
   logic [31:0]          r_addr;
   logic [31:0]          r_data;
   logic [3:0]           r_strb;
   logic                 r_awready;
   logic                 r_wready;
   logic                 r_bvalid;
   logic [1:0]           r_bresp;
   logic                 r_wr_pulse;
   logic [c_IDX_W-1:0]   r_wr_index;
   logic [31:0]          r_regs [NUM_REGS];

   logic                 w_aw_hs;
   logic                 w_w_hs;
   logic                 w_do_write;
   logic                 w_b_done;
   logic                 w_awready_next;
   logic                 w_wready_next;
   logic [c_IDX_W-1:0]   w_idx;
   logic                 w_in_range;

   // Word index from the bits just above the byte offset. Any set bit above
   // the index field makes the access out of range.
   assign w_idx      = c_IDX_W'(r_addr >> ADDR_LSB);
   assign w_in_range = ((r_addr >> (ADDR_LSB + c_IDX_W)) == 32'd0);

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_state <= S_COLLECT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // The ready flags are registered. Their next values are computed here so
   // that READY never follows VALID combinationally.
   always_comb begin
      w_state_next   = r_state;
      w_aw_hs        = 1'b0;
      w_w_hs         = 1'b0;
      w_do_write     = 1'b0;
      w_b_done       = 1'b0;
      w_awready_next = 1'b0;
      w_wready_next  = 1'b0;
      case (r_state)
         S_COLLECT: begin
            if (r_aw_held && r_w_held) begin
               w_do_write   = 1'b1;
               w_state_next = S_RESP;
            end else begin
               w_aw_hs        = s_axi.AWVALID && r_awready;
               w_w_hs         = s_axi.WVALID && r_wready;
               w_awready_next = !(r_aw_held || w_aw_hs);
               w_wready_next  = !(r_w_held || w_w_hs);
            end
         end
         S_RESP: begin
            if (r_bvalid && s_axi.BREADY) begin
               w_b_done       = 1'b1;
               w_state_next   = S_COLLECT;
               w_awready_next = 1'b1;
               w_wready_next  = 1'b1;
            end
         end
         default: begin
            w_state_next = S_COLLECT;
         end
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESET) begin
      if (!ARESET) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_strb     <= '0;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_bvalid   <= 1'b0;
         r_bresp    <= c_OKAY;
         r_wr_pulse <= 1'b0;
         r_wr_index <= '0;
         for (int k = 0; k < NUM_REGS; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         r_awready  <= w_awready_next;
         r_wready   <= w_wready_next;
         r_wr_pulse <= 1'b0;
         if (w_aw_hs) begin
            r_addr    <= s_axi.AWADDR;
            r_aw_held <= 1'b1;
         end
         if (w_w_hs) begin
            r_data   <= s_axi.WDATA;
            r_strb   <= s_axi.WSTRB;
            r_w_held <= 1'b1;
         end
         if (w_do_write) begin
            r_bvalid <= 1'b1;
            if (w_in_range) begin
               for (int b = 0; b < 4; b++) begin
                  if (r_strb[b]) begin
                     r_regs[w_idx][8*b +: 8] <= r_data[8*b +: 8];
                  end
               end
               r_bresp    <= c_OKAY;
               r_wr_pulse <= 1'b1;
               r_wr_index <= w_idx;
            end else begin
               r_bresp <= c_SLVERR;
            end
         end
         if (w_b_done) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
      end
   end

   assign s_axi.AWREADY = r_awready;
   assign s_axi.WREADY  = r_wready;
   assign s_axi.BVALID  = r_bvalid;
   assign s_axi.BRESP   = r_bresp;
   assign wr_pulse      = r_wr_pulse;
   assign wr_index      = r_wr_index;

   for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
      assign reg_out[32*k +: 32] = r_regs[k];
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_write_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_lite_write_slave
//  Description : Self-checking bench for axi_lite_write_slave. Directed
//                scenarios are followed by randomized writes. All writes are
//                checked against a word-level register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_write_slave;
   localparam int NUM_REGS = 4;
   localparam int ADDR_LSB = 2;

   logic                  ACLK   = 1'b0;
   logic                  ARESET = 1'b0;
   logic [NUM_REGS*32-1:0] reg_out;
   logic                  wr_pulse;
   logic [1:0]            wr_index;

   axi_lite_write_slave_if bus ();

   axi_lite_write_slave #(
      .NUM_REGS (NUM_REGS),
      .ADDR_LSB (ADDR_LSB)
   ) dut (
      .ACLK     (ACLK),
      .ARESET   (ARESET),
      .s_axi    (bus),
      .reg_out  (reg_out),
      .wr_pulse (wr_pulse),
      .wr_index (wr_index)
   );

   always #5 ACLK = ~ACLK;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_regs [NUM_REGS];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_flat();
      logic [127:0] f;
      f = '0;
      for (int k = 0; k < NUM_REGS; k++) f[32*k +: 32] = m_regs[k];
      return f;
   endfunction

   // Register model: a register exists at every byte address below
   // NUM_REGS*4. Strobed bytes are merged in through a byte mask.
   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output bit ok, output int idx);
      logic [31:0] mask;
      ok  = (addr < NUM_REGS * 4);
      idx = int'((addr / 4) % NUM_REGS);
      mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
      if (ok) m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_REGS; k++) m_regs[k] = '0;
   endtask

   // One complete write. Inputs are driven on the falling edge and outputs
   // are sampled there. A handshake seen at falling edge c completes at
   // rising edge c+1. BVALID first seen at falling edge c rose at edge c.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_dly, input bit abort_on_b, input string tag);
      bit aw_done = 0, w_done = 0, aw_flag = 0, w_flag = 0, b_flag = 0, b_done = 0;
      bit seen_b = 0, exp_ok;
      int aw_edge = 0, w_edge = 0, b_first = -1, pulses = 0, pulse_cyc = -1, viol = 0, exp_idx;
      logic [1:0] idx_seen = 2'd0, resp_first = 2'd0;
      model_write(addr, data, strb, exp_ok, exp_idx);
      for (int cyc = 0; cyc < 80 && !b_done; cyc++) begin
         @(negedge ACLK);
         if (aw_flag) begin aw_done = 1; aw_flag = 0; bus.AWVALID = 1'b0; end
         if (w_flag)  begin w_done = 1;  w_flag = 0;  bus.WVALID = 1'b0; end
         if (b_flag) begin
            b_done = 1;
            bus.BREADY = 1'b0;
            check({tag, "_bvalid_drop"}, bus.BVALID, 1'b0);
            check({tag, "_ready_back"}, {bus.AWREADY, bus.WREADY}, 2'b11);
         end else begin
            if (wr_pulse) begin pulses++; pulse_cyc = cyc; idx_seen = wr_index; end
            if (w_done && !aw_done && bus.WREADY) viol++;
            if (aw_done && !w_done && bus.AWREADY) viol++;
            if (bus.BVALID) begin
               if (!seen_b) begin
                  seen_b = 1; b_first = cyc; resp_first = bus.BRESP;
                  if (abort_on_b) begin
                     bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
                     #2 ARESET = 1'b0;
                     #1;
                     check({tag, "_rst_bvalid"}, bus.BVALID, 1'b0);
                     check({tag, "_rst_ready"}, {bus.AWREADY, bus.WREADY}, 2'b00);
                     check({tag, "_rst_regs"}, reg_out, 128'd0);
                     check({tag, "_rst_pulse"}, wr_pulse, 1'b0);
                     model_reset();
                     return;
                  end
               end else if (bus.BRESP !== resp_first) viol++;
               if (bus.AWREADY || bus.WREADY) viol++;
            end
            if (!aw_done && cyc >= aw_dly) begin bus.AWVALID = 1'b1; bus.AWADDR = addr; end
            if (!w_done && cyc >= w_dly) begin
               bus.WVALID = 1'b1; bus.WDATA = data; bus.WSTRB = strb;
            end
            if (b_dly == 0 || (seen_b && cyc >= b_first + b_dly)) bus.BREADY = 1'b1;
            if (bus.AWVALID && bus.AWREADY && !aw_done) begin aw_flag = 1; aw_edge = cyc + 1; end
            if (bus.WVALID && bus.WREADY && !w_done) begin w_flag = 1; w_edge = cyc + 1; end
            b_flag = bus.BVALID && bus.BREADY;
         end
      end
      check({tag, "_complete"}, b_done, 1'b1);
      if (b_done) begin
         check({tag, "_bresp"}, resp_first, exp_ok ? 2'b00 : 2'b10);
         check({tag, "_pulses"}, pulses, exp_ok ? 1 : 0);
         if (exp_ok) begin
            check({tag, "_wr_index"}, idx_seen, exp_idx[1:0]);
            check({tag, "_pulse_time"}, pulse_cyc, b_first);
         end
         check({tag, "_latency"}, b_first, ((aw_edge > w_edge) ? aw_edge : w_edge) + 1);
         check({tag, "_protocol"}, viol, 0);
         check({tag, "_regs"}, reg_out, model_flat());
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired after %0d checks", n_checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      bus.AWVALID = 1'b0; bus.AWADDR = '0; bus.WVALID = 1'b0;
      bus.WDATA = '0; bus.WSTRB = '0; bus.BREADY = 1'b0;
      model_reset();

      repeat (3) @(negedge ACLK);
      check("rst_ready", {bus.AWREADY, bus.WREADY}, 2'b00);
      check("rst_b", {bus.BVALID, bus.BRESP}, 3'b000);
      check("rst_pulse", {wr_pulse, wr_index}, 3'b000);
      check("rst_regs", reg_out, 128'd0);
      ARESET = 1'b1;
      @(negedge ACLK);
      check("rel_ready", {bus.AWREADY, bus.WREADY}, 2'b11);

      // Same-cycle AW and W.
      axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, "t1");
      check("t1_reg1", reg_out[63:32], 32'hDEADBEEF);

      // W arrives three cycles ahead of AW into a preloaded register.
      axi_write(32'h8, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0, "t2pre");
      axi_write(32'h8, 32'h11223344, 4'b0101, 3, 0, 0, 0, "t2");
      check("t2_reg2", reg_out[95:64], 32'hAA22CC44);

      // Out of range.
      axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 0, "t3");

      // BREADY held back after BVALID.
      axi_write(32'hC, 32'h12345678, 4'hF, 1, 0, 5, 0, "t4");

      // Back-to-back writes, plus an empty strobe.
      axi_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, "t5a");
      axi_write(32'hC, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, "t5b");
      axi_write(32'h4, 32'h55555555, 4'h0, 0, 2, 0, 0, "t5z");

      // Reset while the response is pending.
      axi_write(32'h4, 32'h87654321, 4'hF, 0, 0, 3, 1, "t6");
      @(negedge ACLK);
      ARESET = 1'b1;
      @(negedge ACLK);
      check("t6_rel_ready", {bus.AWREADY, bus.WREADY}, 2'b11);
      axi_write(32'h8, 32'h0F0F0F0F, 4'hF, 0, 1, 0, 0, "t6post");

      for (int i = 0; i < 40; i++) begin
         a = 32'($urandom_range(0, 23));
         if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
         axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom_range(0, 4), 0, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
